cache_hierarchy: RTL and testbench
==================================

Name: cache_hierarchy

Overview:
Shared second-level cache that serves four L1 clients on one clock: HP-core I-cache (HPi), HP-core D-cache (HPd), LP-core I-cache (LPi) and LP-core D-cache (LPd). Each client issues whole-line (256-bit) reads or writes on an 11-bit line address. A round-robin arbiter grants one request at a time. The granted request goes to a direct-mapped, write-back, write-allocate L2, which is backed by an internal main-memory model with fixed latency.

Parameters:
ADDR_W, 11, line-address width (2048 lines)
LINE_W, 256, line/data width in bits
L2_IDX_W, 6, L2 index bits (64 sets); tag = ADDR_W-L2_IDX_W = 5 bits
MEM_LAT, 4, main-memory access latency in cycles (read or write), must be >=1

Ports:
clk  in  1  clock; all state updates on rising edge
rstn  in  1  reset, asynchronous, active-low
L1_HPi_req / L1_HPd_req / L1_LPi_req / L1_LPd_req  in  1  request, level, held until ack
L1_HPd_we / L1_LPd_we  in  1  1=write line, 0=read (I ports always read)
L1_HPi_addr / L1_HPd_addr / L1_LPi_addr / L1_LPd_addr  in  11  line address
L1_HPd_wdata / L1_LPd_wdata  in  256  write line data
L1_HPi_ack / L1_HPd_ack / L1_LPi_ack / L1_LPd_ack  out  1  one-cycle completion pulse
L1_HPi_ready_o / L1_HPd_ready_o / L1_LPi_ready_o / L1_LPd_ready_o  out  1  port has no transaction in service
L1_HPi_rdata / L1_HPd_rdata / L1_LPi_rdata / L1_LPd_rdata  out  256  read line, valid with ack, held until the next read ack on that port

Behaviour:
- Reset (rstn=0, async):
  - All acks=0; all ready_o=1; all rdata=0.
  - FSM goes to IDLE; round-robin pointer set to HPi.
  - All L2 valid and dirty bits are cleared.
  - L2 data array and main memory are not reset. Main memory initialises to all-zero at time 0.
  - Reset during any state aborts the transaction. An in-flight memory write-back may be lost.
- Arbitration, in IDLE only:
  - Eligible ports: req=1 AND ack not asserted this cycle. This prevents re-granting a req the client drops on the ack edge.
  - Round-robin order HPi -> HPd -> LPi -> LPd. Search starts at the pointer. After a grant, the pointer moves to the port after the granted one.
  - On a grant edge, the FSM latches port id, addr, we, and wdata (we and wdata forced to 0 for I ports), and the granted port's ready_o drops to 0.
- FSM states: IDLE, LOOKUP, WBACK, REFILL, RESP.
  - IDLE -> LOOKUP on grant.
  - LOOKUP compares the tag at index addr[5:0] against addr[10:6]:
    - Hit -> RESP. Read returns the L2 line. Write overwrites the line and sets dirty.
    - Miss with victim valid & dirty -> WBACK.
    - Miss otherwise -> REFILL for a read, or RESP for a write (full-line write, no fetch; install tag, valid=1, dirty=1).
  - WBACK: writes the victim line to memory[{victim_tag,index}], taking MEM_LAT cycles. Then -> REFILL for a read, or -> RESP after installing the write line.
  - REFILL: reads memory[addr], taking MEM_LAT cycles. Installs the line with valid=1, dirty=0, then -> RESP.
  - RESP: asserts the granted port's ack for exactly 1 cycle. For a read, loads that port's rdata with the line; for a write, rdata is unchanged. Granted ready_o returns to 1 in the same cycle. Next state IDLE.
- Latency from grant edge to ack-high cycle:
  - Hit: 2 cycles.
  - Clean read miss: 2+MEM_LAT.
  - Write miss, clean victim: 2.
  - Dirty read miss: 2+2*MEM_LAT.
  - Dirty write miss: 2+MEM_LAT.
- Only one transaction is in flight at a time. Non-granted requests wait with ready_o=1.
- Only one ack is high in any cycle.
- Requests that change addr/we/wdata after grant have no effect on the latched transaction.
- The outputs of idle ports stay constant.

Test Plan:
- Reset release with simultaneous requests: HPi rd 0, HPd wr 400 data 0x101, LPi rd 1, LPd wr 401 data 0x202. Required results:
  - Acks arrive in order HPi, HPd, LPi, LPd, each a single pulse.
  - HPi and LPi rdata = 0.
  - Each client drops req on ack, and no port is granted twice.
- Read-after-write hit: after the first scenario, HPi rd 400 -> ack 2 cycles after grant, rdata = 0x101. LPd rd 401 -> 0x202.
- Dirty eviction: HPd wr 464 data 0xAA (same index 16 as 400, dirty victim). Required results:
  - Ack at 2+MEM_LAT cycles.
  - Then LPd rd 400 -> refill after a second write-back, ack at 2+2*MEM_LAT, rdata = 0x101.
- Fairness: hold all four reqs continuously, re-asserting each one after its ack. Grants must rotate HPi, HPd, LPi, LPd repeatedly, and ready_o=0 only for the port in service.
- Reset mid-REFILL: rstn=0 during a read miss. Required results:
  - Acks go to 0 immediately and ready_o goes to 1.
  - After release, a read of the previously-hit address 400 misses (valid bits cleared).
- ack/ready check: in every cycle, at most one ack is high, and the acked port's ready_o is high in its ack cycle.

Source files
------------

// File: rtl/cache_hierarchy.sv
// Shared L2 for four L1 clients: round-robin arbiter, direct-mapped write-back /
// write-allocate L2, and a fixed-latency main-memory model behind it.
module cache_hierarchy #(
  parameter int ADDR_W   = 11,
  parameter int LINE_W   = 256,
  parameter int L2_IDX_W = 6,
  parameter int MEM_LAT  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              L1_HPi_req,
  input  logic              L1_HPd_req,
  input  logic              L1_LPi_req,
  input  logic              L1_LPd_req,
  input  logic              L1_HPd_we,
  input  logic              L1_LPd_we,
  input  logic [ADDR_W-1:0] L1_HPi_addr,
  input  logic [ADDR_W-1:0] L1_HPd_addr,
  input  logic [ADDR_W-1:0] L1_LPi_addr,
  input  logic [ADDR_W-1:0] L1_LPd_addr,
  input  logic [LINE_W-1:0] L1_HPd_wdata,
  input  logic [LINE_W-1:0] L1_LPd_wdata,
  output logic              L1_HPi_ack,
  output logic              L1_HPd_ack,
  output logic              L1_LPi_ack,
  output logic              L1_LPd_ack,
  output logic              L1_HPi_ready_o,
  output logic              L1_HPd_ready_o,
  output logic              L1_LPi_ready_o,
  output logic              L1_LPd_ready_o,
  output logic [LINE_W-1:0] L1_HPi_rdata,
  output logic [LINE_W-1:0] L1_HPd_rdata,
  output logic [LINE_W-1:0] L1_LPi_rdata,
  output logic [LINE_W-1:0] L1_LPd_rdata
);

  localparam int TAG_W = ADDR_W - L2_IDX_W;
  localparam int SETS  = 1 << L2_IDX_W;
  localparam int LINES = 1 << ADDR_W;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WBACK  = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state_q;
  logic [1:0]        ptr_q;
  logic [1:0]        port_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fill_q;
  logic [3:0]        ack_q;
  logic [LINE_W-1:0] rdata_q [4];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q [SETS];

  logic [LINE_W-1:0] l2_ram [SETS];
  logic [LINE_W-1:0] mem_ram [LINES];
  logic [LINE_W-1:0] l2_rd_q;
  logic [LINE_W-1:0] mem_rd_q;

  // Port order 0..3 = HPi, HPd, LPi, LPd; I ports never write.
  logic [3:0]        req;
  logic [3:0]        we_in;
  logic [ADDR_W-1:0] addr_in [4];
  logic [LINE_W-1:0] wdata_in [4];

  assign req        = {L1_LPd_req, L1_LPi_req, L1_HPd_req, L1_HPi_req};
  assign we_in      = {L1_LPd_we, 1'b0, L1_HPd_we, 1'b0};
  assign addr_in[0] = L1_HPi_addr;
  assign addr_in[1] = L1_HPd_addr;
  assign addr_in[2] = L1_LPi_addr;
  assign addr_in[3] = L1_LPd_addr;
  assign wdata_in[0] = '0;
  assign wdata_in[1] = L1_HPd_wdata;
  assign wdata_in[2] = '0;
  assign wdata_in[3] = L1_LPd_wdata;

  // A port whose ack is high this cycle is excluded so a req dropped on the ack edge is not re-granted.
  logic [3:0] elig;
  logic       grant_vld;
  logic [1:0] grant_id;

  assign elig = req & ~ack_q;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (elig[ptr_q + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_id  = ptr_q + 2'(k);
      end
    end
  end

  logic [L2_IDX_W-1:0] idx;
  logic [TAG_W-1:0]    tag_in;
  logic                hit;
  logic                victim_dirty;
  logic                cnt_last;

  assign idx          = addr_q[L2_IDX_W-1:0];
  assign tag_in       = addr_q[ADDR_W-1:L2_IDX_W];
  assign hit          = valid_q[idx] && (tag_q[idx] == tag_in);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign cnt_last     = (cnt_q == '0);

  logic              l2_we;
  logic [LINE_W-1:0] l2_wline;
  logic              mem_we;

  always_comb begin
    l2_we    = 1'b0;
    l2_wline = wdata_q;
    mem_we   = 1'b0;
    case (state_q)
      S_LOOKUP: l2_we = we_q && (hit || !victim_dirty);
      S_WBACK: begin
        mem_we = cnt_last;
        l2_we  = cnt_last && we_q;
      end
      S_REFILL: begin
        l2_we    = cnt_last;
        l2_wline = mem_rd_q;
      end
      default: ;
    endcase
  end

  // Both RAMs read every cycle at the latched address; the victim line and the
  // refill line are therefore stable by the time WBACK/REFILL consume them.
  always_ff @(posedge clk) begin
    if (l2_we) l2_ram[idx] <= l2_wline;
    l2_rd_q <= l2_ram[idx];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_ram[{tag_q[idx], idx}] <= l2_rd_q;
    mem_rd_q <= mem_ram[addr_q];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      port_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      ack_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < SETS; i++) tag_q[i] <= '0;
      for (int p = 0; p < 4; p++) rdata_q[p] <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            port_q  <= grant_id;
            addr_q  <= addr_in[grant_id];
            we_q    <= we_in[grant_id];
            wdata_q <= wdata_in[grant_id];
            ptr_q   <= grant_id + 2'd1;
            fill_q  <= 1'b0;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (we_q) dirty_q[idx] <= 1'b1;
            state_q <= S_RESP;
          end else if (victim_dirty) begin
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            state_q <= S_WBACK;
          end else if (we_q) begin
            tag_q[idx]   <= tag_in;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            state_q <= S_REFILL;
          end
        end
        S_WBACK: begin
          if (!cnt_last) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (we_q) begin
            tag_q[idx]   <= tag_in;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (!cnt_last) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            tag_q[idx]   <= tag_in;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            fill_q       <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          ack_q[port_q] <= 1'b1;
          // After a refill the L2 read register still holds the pre-install line.
          if (!we_q) rdata_q[port_q] <= fill_q ? mem_rd_q : l2_rd_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [3:0] ready;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    assign ready[gi] = (state_q == S_IDLE) || (port_q != 2'(gi));
  end

  assign L1_HPi_ack     = ack_q[0];
  assign L1_HPd_ack     = ack_q[1];
  assign L1_LPi_ack     = ack_q[2];
  assign L1_LPd_ack     = ack_q[3];
  assign L1_HPi_ready_o = ready[0];
  assign L1_HPd_ready_o = ready[1];
  assign L1_LPi_ready_o = ready[2];
  assign L1_LPd_ready_o = ready[3];
  assign L1_HPi_rdata   = rdata_q[0];
  assign L1_HPd_rdata   = rdata_q[1];
  assign L1_LPi_rdata   = rdata_q[2];
  assign L1_LPd_rdata   = rdata_q[3];

endmodule

// File: tb/tb_cache_hierarchy.sv
// Randomised bench for cache_hierarchy: concurrent client drivers checked
// against a cache/memory reference model plus per-cycle ack/ready invariants.
module tb_cache_hierarchy;
  localparam int L    = 4;
  localparam int MAXN = 6;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   req_tb = '0;
  logic [3:0]   we_tb = '0;
  logic [10:0]  addr_tb [4];
  logic [255:0] wdata_tb [4];
  wire  [3:0]   ack_w;
  wire  [3:0]   ready_w;
  wire  [255:0] rdata_w [4];

  cache_hierarchy dut (
    .clk(clk), .rstn(rstn),
    .L1_HPi_req(req_tb[0]), .L1_HPd_req(req_tb[1]), .L1_LPi_req(req_tb[2]), .L1_LPd_req(req_tb[3]),
    .L1_HPd_we(we_tb[1]), .L1_LPd_we(we_tb[3]),
    .L1_HPi_addr(addr_tb[0]), .L1_HPd_addr(addr_tb[1]), .L1_LPi_addr(addr_tb[2]), .L1_LPd_addr(addr_tb[3]),
    .L1_HPd_wdata(wdata_tb[1]), .L1_LPd_wdata(wdata_tb[3]),
    .L1_HPi_ack(ack_w[0]), .L1_HPd_ack(ack_w[1]), .L1_LPi_ack(ack_w[2]), .L1_LPd_ack(ack_w[3]),
    .L1_HPi_ready_o(ready_w[0]), .L1_HPd_ready_o(ready_w[1]),
    .L1_LPi_ready_o(ready_w[2]), .L1_LPd_ready_o(ready_w[3]),
    .L1_HPi_rdata(rdata_w[0]), .L1_HPd_rdata(rdata_w[1]), .L1_LPi_rdata(rdata_w[2]), .L1_LPd_rdata(rdata_w[3])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle invariants and grant detection (ready falling marks the grant edge).
  int           grant_cyc [4];
  int           grant_log [$];
  logic [3:0]   ready_prev = 4'hF;
  logic         rst_prev = 1'b0;
  logic [255:0] rd_prev [4];

  always @(negedge clk) begin
    if (rstn) begin
      check_val("ack_at_most_one", ($countones(ack_w) <= 1), 1'b1);
      check_val("ready_low_at_most_one", ($countones(~ready_w) <= 1), 1'b1);
      for (int p = 0; p < 4; p++) begin
        if (ack_w[p]) check_val($sformatf("ready_in_ack p%0d", p), ready_w[p], 1'b1);
        if (rst_prev && !ack_w[p]) check_val($sformatf("rdata_hold p%0d", p), rdata_w[p], rd_prev[p]);
        if (ready_prev[p] && !ready_w[p]) begin
          grant_cyc[p] = cyc;
          grant_log.push_back(p);
        end
      end
    end
    ready_prev = ready_w;
    rst_prev   = rstn;
    for (int p = 0; p < 4; p++) rd_prev[p] = rdata_w[p];
  end

  // Reference model: L2 as tag/valid/dirty/line per set, memory as a flat line array.
  logic [255:0] mm [2048];
  logic [255:0] md [64];
  logic [4:0]   mt [64];
  bit           mv [64];
  bit           mdt [64];
  logic [255:0] port_rd [4];
  int           m_ptr;

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      mv[s]  = 1'b0;
      mdt[s] = 1'b0;
    end
    for (int p = 0; p < 4; p++) port_rd[p] = '0;
    m_ptr = 0;
  endfunction

  function automatic void model_txn(input int p, input bit we, input logic [10:0] a,
                                    input logic [255:0] d, output int lat, output logic [255:0] rd);
    int s;
    logic [4:0] t;
    s   = int'(a[5:0]);
    t   = a[10:6];
    lat = 2;
    if (!(mv[s] && mt[s] == t)) begin
      if (mv[s] && mdt[s]) begin
        mm[{mt[s], a[5:0]}] = md[s];
        lat += L;
      end
      mv[s]  = 1'b1;
      mt[s]  = t;
      mdt[s] = 1'b0;
      if (!we) begin
        md[s] = mm[a];
        lat += L;
      end
    end
    if (we) begin
      md[s]  = d;
      mdt[s] = 1'b1;
    end else begin
      port_rd[p] = md[s];
    end
    rd = port_rd[p];
  endfunction

  logic [10:0]  s_addr [4][MAXN];
  bit           s_we   [4][MAXN];
  logic [255:0] s_dat  [4][MAXN];
  int           e_lat  [4][MAXN];
  logic [255:0] e_rd   [4][MAXN];
  int           e_order [$];
  int           last_lat [4];
  logic [255:0] last_rd [4];

  // Expected grant order: rotation from the model pointer among requesting ports.
  task automatic plan(input logic [3:0] mask, input int n);
    int cnt [4];
    int p;
    e_order.delete();
    for (int q = 0; q < 4; q++) cnt[q] = 0;
    for (int t = 0; t < n * $countones(mask); t++) begin
      p = -1;
      for (int k = 0; k < 4; k++) begin
        if (p < 0 && mask[(m_ptr + k) % 4]) p = (m_ptr + k) % 4;
      end
      model_txn(p, s_we[p][cnt[p]], s_addr[p][cnt[p]], s_dat[p][cnt[p]], e_lat[p][cnt[p]], e_rd[p][cnt[p]]);
      cnt[p]++;
      m_ptr = (p + 1) % 4;
      e_order.push_back(p);
    end
  endtask

  task automatic drive(input int p, input int n);
    for (int j = 0; j < n; j++) begin
      int  waited;
      bit  got;
      waited = 0;
      got    = 1'b0;
      addr_tb[p]  = s_addr[p][j];
      we_tb[p]    = s_we[p][j];
      wdata_tb[p] = s_dat[p][j];
      req_tb[p]   = 1'b1;
      while (!got && waited < 200) begin
        @(negedge clk);
        waited++;
        if (ack_w[p]) got = 1'b1;
      end
      if (!got) begin
        check_val($sformatf("ack_timeout p%0d", p), 1'b0, 1'b1);
        req_tb[p] = 1'b0;
        return;
      end
      last_lat[p] = cyc - grant_cyc[p];
      last_rd[p]  = rdata_w[p];
      check_val($sformatf("latency p%0d txn%0d", p, j), last_lat[p], e_lat[p][j]);
      check_val($sformatf("rdata p%0d txn%0d", p, j), rdata_w[p], e_rd[p][j]);
      @(posedge clk);
      #1 req_tb[p] = 1'b0;
      if (j < n - 1) @(negedge clk);
    end
  endtask

  task automatic run(input logic [3:0] mask, input int n);
    plan(mask, n);
    grant_log.delete();
    fork
      if (mask[0]) drive(0, n);
      if (mask[1]) drive(1, n);
      if (mask[2]) drive(2, n);
      if (mask[3]) drive(3, n);
    join
    check_val("grant_count", grant_log.size(), e_order.size());
    for (int k = 0; k < grant_log.size() && k < e_order.size(); k++)
      check_val($sformatf("grant_order #%0d", k), grant_log[k], e_order[k]);
  endtask

  task automatic gen(input int n);
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < n; j++) begin
        s_addr[p][j] = {5'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
        s_we[p][j]   = (p == 1 || p == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        s_dat[p][j]  = {8{$urandom()}};
      end
    end
  endtask

  task automatic set1(input int p, input logic [10:0] a, input bit we, input logic [255:0] d);
    s_addr[p][0] = a;
    s_we[p][0]   = we;
    s_dat[p][0]  = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bit seen;
    for (int i = 0; i < 2048; i++) mm[i] = '0;
    for (int p = 0; p < 4; p++) begin
      addr_tb[p]  = '0;
      wdata_tb[p] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      check_val($sformatf("reset ack p%0d", p), ack_w[p], 1'b0);
      check_val($sformatf("reset ready p%0d", p), ready_w[p], 1'b1);
      check_val($sformatf("reset rdata p%0d", p), rdata_w[p], '0);
    end

    // Simultaneous requests at reset release.
    set1(0, 11'd0, 1'b0, '0);
    set1(1, 11'd400, 1'b1, 256'h101);
    set1(2, 11'd1, 1'b0, '0);
    set1(3, 11'd401, 1'b1, 256'h202);
    rstn = 1'b1;
    run(4'hF, 1);
    check_val("s1 HPi rdata", last_rd[0], '0);
    check_val("s1 LPi rdata", last_rd[2], '0);
    check_val("s1 HPi clean miss latency", last_lat[0], 2 + L);

    // Read-after-write hits.
    @(negedge clk);
    set1(0, 11'd400, 1'b0, '0);
    run(4'h1, 1);
    check_val("hit latency HPi 400", last_lat[0], 2);
    check_val("hit rdata HPi 400", last_rd[0], 256'h101);
    @(negedge clk);
    set1(3, 11'd401, 1'b0, '0);
    run(4'h8, 1);
    check_val("hit rdata LPd 401", last_rd[3], 256'h202);

    // Dirty evictions on set 16.
    @(negedge clk);
    set1(1, 11'd464, 1'b1, 256'hAA);
    run(4'h2, 1);
    check_val("dirty write miss latency", last_lat[1], 2 + L);
    @(negedge clk);
    set1(3, 11'd400, 1'b0, '0);
    run(4'h8, 1);
    check_val("dirty read miss latency", last_lat[3], 2 + 2 * L);
    check_val("dirty read miss rdata", last_rd[3], 256'h101);

    // Reset in the middle of a clean read-miss refill.
    @(negedge clk);
    addr_tb[0] = 11'd2;
    req_tb[0]  = 1'b1;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      if (!ready_w[0]) seen = 1'b1;
    end
    check_val("midreset grant seen", seen, 1'b1);
    repeat (3) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check_val("midreset acks", ack_w, 4'h0);
    check_val("midreset ready", ready_w, 4'hF);
    check_val("midreset HPi rdata", rdata_w[0], '0);
    req_tb[0] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    set1(0, 11'd400, 1'b0, '0);
    run(4'h1, 1);
    check_val("post-reset 400 miss latency", last_lat[0], 2 + L);
    check_val("post-reset 400 rdata", last_rd[0], 256'h101);

    // Fairness with all four clients continuously requesting.
    gen(3);
    @(negedge clk);
    run(4'hF, 3);

    // Random mixes of clients, depths and addresses.
    repeat (10) begin
      logic [3:0] mask;
      int n;
      mask = 4'($urandom_range(1, 15));
      n    = $urandom_range(1, 4);
      gen(n);
      @(negedge clk);
      run(mask, n);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
